// File: rtl/lmsm_sequencer_pkg.sv
// Shared constants, field positions and state encoding for the LM/SM expander.
package lmsm_sequencer_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned NREG   = 8;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned OPC_W  = 4;

   localparam logic [OPC_W-1:0] OP_LM = 4'b0110;
   localparam logic [OPC_W-1:0] OP_SM = 4'b0111;
   localparam logic [OPC_W-1:0] OP_LW = 4'b0100;
   localparam logic [OPC_W-1:0] OP_SW = 4'b0101;

   localparam int unsigned OPC_HI  = 15;
   localparam int unsigned OPC_LO  = 12;
   localparam int unsigned RA_HI   = 11;
   localparam int unsigned RA_LO   = 9;
   localparam int unsigned LIST_HI = 7;
   localparam int unsigned LIST_LO = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEQ  = 1'b1
   } st_e;

   // LW/SW micro-instruction layout: opcode, data reg, base reg, imm6
   typedef struct packed {
      logic [OPC_W-1:0] opc;
      logic [IDX_W-1:0] rd;
      logic [IDX_W-1:0] ra;
      logic [5:0]       imm;
   } ls_instr_t;

   // Build one micro-op; the offset is the issue order, so it never exceeds 7
   function automatic logic [DATA_W-1:0] micro_op(input logic             ld,
                                                  input logic [IDX_W-1:0] rd,
                                                  input logic [IDX_W-1:0] ra,
                                                  input logic [IDX_W-1:0] off);
      ls_instr_t u;
      u.opc = ld ? OP_LW : OP_SW;
      u.rd  = rd;
      u.ra  = ra;
      u.imm = {3'b000, off};
      return u;
   endfunction

endpackage

// File: rtl/lmsm_sequencer_lsb_pick8.sv
// Find-lowest-set-bit over an 8-bit register list.
module lsb_pick8
   import lmsm_sequencer_pkg::*;
(
   input  logic [NREG-1:0]  i_vec,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any,
   output logic             o_more
);

   // Scan downward so the lowest set index is the one left standing
   always_comb begin
      o_idx = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (i_vec[i]) o_idx = IDX_W'(i);
      end
   end

   assign o_any  = |i_vec;
   assign o_more = |(i_vec & (i_vec - NREG'(1)));

endmodule

// File: rtl/lmsm_sequencer.sv
// Decode-stage expander: turns LM/SM into one LW/SW per selected register.
module lmsm_sequencer
   import lmsm_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [DATA_W-1:0] in_pc,
   input  logic              in_valid,
   input  logic              hold,
   input  logic              flush,
   output logic [DATA_W-1:0] out_instr,
   output logic [DATA_W-1:0] out_pc,
   output logic              out_valid,
   output logic              out_last,
   output logic              m_inst
);

   st_e               r_st, w_st_nxt;
   logic [NREG-1:0]   r_rem_mask, w_rem_mask_nxt;
   logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]  r_base, w_base_nxt;
   logic              r_is_ld, w_is_ld_nxt;
   logic [DATA_W-1:0] r_pc_q, w_pc_q_nxt;
   logic [DATA_W-1:0] r_out_instr, w_out_instr_nxt;
   logic [DATA_W-1:0] r_out_pc, w_out_pc_nxt;
   logic              r_out_valid, w_out_valid_nxt;
   logic              r_out_last, w_out_last_nxt;

   logic [OPC_W-1:0]  w_opc;
   logic              w_is_lmsm;
   logic [NREG-1:0]   w_list;
   logic [IDX_W-1:0]  w_ra;
   logic [NREG-1:0]   w_pick_vec;
   logic [IDX_W-1:0]  w_idx;
   logic              w_any;
   logic              w_more;
   logic [NREG-1:0]   w_clr_mask;

   assign w_opc     = in_instr[OPC_HI:OPC_LO];
   assign w_is_lmsm = (w_opc == OP_LM) || (w_opc == OP_SM);
   assign w_list    = in_instr[LIST_HI:LIST_LO];
   assign w_ra      = in_instr[RA_HI:RA_LO];

   // One picker serves both the incoming list (IDLE) and the remaining mask (SEQ)
   assign w_pick_vec = (r_st == ST_SEQ) ? r_rem_mask : w_list;
   assign w_clr_mask = w_pick_vec & ~(NREG'(1) << w_idx);

   lsb_pick8 u_pick (
      .i_vec  (w_pick_vec),
      .o_idx  (w_idx),
      .o_any  (w_any),
      .o_more (w_more)
   );

   // More micro-ops remain after this cycle; killed at once by flush or reset
   assign m_inst = ~reset & ~flush & w_more &
                   ((r_st == ST_SEQ) || (in_valid && w_is_lmsm));

   // Next-state and next-output selection: flush > hold > normal
   always_comb begin
      w_st_nxt        = r_st;
      w_rem_mask_nxt  = r_rem_mask;
      w_cnt_nxt       = r_cnt;
      w_base_nxt      = r_base;
      w_is_ld_nxt     = r_is_ld;
      w_pc_q_nxt      = r_pc_q;
      w_out_instr_nxt = r_out_instr;
      w_out_pc_nxt    = r_out_pc;
      w_out_valid_nxt = r_out_valid;
      w_out_last_nxt  = r_out_last;

      if (flush) begin
         w_st_nxt        = ST_IDLE;
         w_rem_mask_nxt  = '0;
         w_out_valid_nxt = 1'b0;
      end else if (!hold) begin
         case (r_st)
            ST_IDLE: begin
               if (!in_valid) begin
                  w_out_valid_nxt = 1'b0;
                  w_out_last_nxt  = 1'b0;
               end else if (!w_is_lmsm) begin
                  w_out_instr_nxt = in_instr;
                  w_out_pc_nxt    = in_pc;
                  w_out_valid_nxt = 1'b1;
                  w_out_last_nxt  = 1'b1;
               end else if (!w_any) begin
                  w_out_valid_nxt = 1'b0;
                  w_out_last_nxt  = 1'b0;
               end else begin
                  w_out_instr_nxt = micro_op(w_opc == OP_LM, w_idx, w_ra, '0);
                  w_out_pc_nxt    = in_pc;
                  w_out_valid_nxt = 1'b1;
                  w_out_last_nxt  = ~w_more;
                  if (w_more) begin
                     w_rem_mask_nxt = w_clr_mask;
                     w_cnt_nxt      = IDX_W'(1);
                     w_base_nxt     = w_ra;
                     w_is_ld_nxt    = (w_opc == OP_LM);
                     w_pc_q_nxt     = in_pc;
                     w_st_nxt       = ST_SEQ;
                  end
               end
            end
            ST_SEQ: begin
               w_out_instr_nxt = micro_op(r_is_ld, w_idx, r_base, r_cnt);
               w_out_pc_nxt    = r_pc_q;
               w_out_valid_nxt = 1'b1;
               w_out_last_nxt  = ~w_more;
               w_rem_mask_nxt  = w_clr_mask;
               w_cnt_nxt       = r_cnt + IDX_W'(1);
               if (!w_more) w_st_nxt = ST_IDLE;
            end
            default: w_st_nxt = ST_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_st        <= ST_IDLE;
         r_rem_mask  <= '0;
         r_cnt       <= '0;
         r_base      <= '0;
         r_is_ld     <= 1'b0;
         r_pc_q      <= '0;
         r_out_instr <= '0;
         r_out_pc    <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         r_st        <= w_st_nxt;
         r_rem_mask  <= w_rem_mask_nxt;
         r_cnt       <= w_cnt_nxt;
         r_base      <= w_base_nxt;
         r_is_ld     <= w_is_ld_nxt;
         r_pc_q      <= w_pc_q_nxt;
         r_out_instr <= w_out_instr_nxt;
         r_out_pc    <= w_out_pc_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_last  <= w_out_last_nxt;
      end
   end

   assign out_instr = r_out_instr;
   assign out_pc    = r_out_pc;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
- Decode-stage expander for multiple-register LM and SM instructions. Sits between the IF/ID register and the ID/RR register, directly upstream of the hazard/flush controller.
- Each LM or SM is turned into one ordinary LW or SW micro-instruction per selected register, one per cycle.
- Drives m_inst into the hazard controller so fetch is held while expansion continues. Every other instruction passes through with a 1-cycle registered latency.

Parameters:
- DATA_W, 16, instruction and PC width
- NREG, 8, architectural registers; also the width of the register-list field
- OP_LM, 4'b0110, load-multiple opcode
- OP_SM, 4'b0111, store-multiple opcode
- OP_LW, 4'b0100, opcode emitted for each LM micro-op
- OP_SW, 4'b0101, opcode emitted for each SM micro-op

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_instr  in  16  instruction from IF/ID
- in_pc  in  16  PC of in_instr
- in_valid  in  1  IF/ID validity bit
- hold  in  1  ID-stage stall; freezes all state and outputs
- flush  in  1  ID-stage kill (ID-stage validity deasserted by the hazard controller)
- out_instr  out  16  registered instruction to ID/RR
- out_pc  out  16  registered PC; all micro-ops carry the parent instruction's PC
- out_valid  out  1  registered validity to ID/RR
- out_last  out  1  registered; marks the final micro-op of an LM/SM, and is 1 for pass-through instructions
- m_inst  out  1  combinational; 1 while more micro-ops remain after the current cycle

Behaviour:
- Instruction fields: opcode = [15:12], RA (base register) = [11:9], register list = [7:0]. List bit i selects Ri. Registers are issued in ascending index order.
- State: st ∈ {IDLE, SEQ}; rem_mask[7:0]; cnt[2:0]; base[2:0]; is_ld; pc_q[15:0].
- Reset (async):
  - st=IDLE, rem_mask=0, cnt=0.
  - out_valid=0, out_instr=16'h0000, out_pc=0, out_last=0.
- Priority at each clock edge: reset > flush > hold > normal operation.
- flush:
  - Next edge: st=IDLE, rem_mask=0, out_valid=0.
  - Any remaining micro-ops are discarded.
  - m_inst drops combinationally in the same cycle.
- hold (without flush): all registers keep their value, m_inst keeps its value, and no micro-op is consumed.
- IDLE, in_valid=0: out_valid<=0.
- IDLE, valid instruction that is not LM/SM: out_instr<=in_instr, out_pc<=in_pc, out_valid<=1, out_last<=1.
- IDLE, valid LM/SM:
  - Let k = lowest set bit of the list.
  - Emit {OP_LW or OP_SW, k, RA, 6'd0}, with out_valid=1.
  - If the list has exactly one bit set: out_last=1 and stay in IDLE.
  - Otherwise: rem_mask = list with bit k cleared, cnt=1, base=RA, pc_q=in_pc, st=SEQ.
- IDLE, LM/SM with an empty list: out_valid<=0 (bubble), stay in IDLE, m_inst=0.
- SEQ, each non-held cycle:
  - Let k = lowest set bit of rem_mask.
  - Emit {op, k, base, 3'b000, cnt} with out_pc=pc_q, then clear bit k and increment cnt.
  - When the cleared mask becomes 0: out_last=1 and st=IDLE.
  - in_instr is ignored while in SEQ; the IF/ID register is frozen upstream.
- m_inst =
  - (st==SEQ and popcount(rem_mask)>=2), or
  - (st==IDLE and in_valid and LM/SM and popcount(list)>=2).
  - It is therefore 0 in the cycle the final micro-op is issued.
- Offsets: the offset is the issue order, not the register index. The maximum is 7 and fits in imm6 without overflow.
- LM including R7: R7 is always the last micro-op, so the R7 writeback flush hits only younger instructions.
- LM whose list includes RA, where RA is not the highest selected index, is architecturally undefined. The block still emits the micro-ops unchanged.
- Reset during SEQ: return to IDLE immediately and drop the remaining micro-ops.
- flush and hold together: flush wins.

Decomposition:
- Shared package: opcode constants (OP_LM, OP_SM, OP_LW, OP_SW), the field bit-position localparams, and the state encoding (IDLE=1'b0, SEQ=1'b1).
- One sub-module: lsb_pick8. Combinational find-lowest-set-bit over 8 bits; outputs idx[2:0], any, and more (at least two bits set).

Test Plan:
- Pass-through: ADD 16'h1234 valid, no hold → next cycle out_instr=16'h1234, out_valid=1, out_last=1, m_inst=0 throughout.
- LM R1, list 8'b1000_0101 → three cycles of LW:
  - R0 off 0, then R2 off 1, then R7 off 2.
  - All carry base R1 and the same out_pc.
  - m_inst=1,1,0; out_last only on the third; then IDLE.
- SM R3, list 8'b0000_0010 → a single SW {0101, 001, 011, 000000}, out_last=1, m_inst never asserted.
- LM list 8'hFF with hold asserted for 2 cycles after the 3rd micro-op → outputs frozen for 2 cycles, then R3..R7 with offsets 3..7. Total of 8 valid micro-ops.
- flush in the cycle after the 2nd micro-op of list 8'hF0 → m_inst=0 the same cycle, out_valid=0 next cycle, IDLE, and the next instruction passes normally.
- Empty list LM, then async reset asserted mid-SEQ of list 8'h0F → first gives a bubble with m_inst=0; the reset clears all outputs to 0 immediately, without waiting for clk.
